// File: rtl/core_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : core_regfile_mp
//  Purpose  : Flop-based multi-port register file with registered read ports,
//             forward/write bypass and a per-register pending scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module core_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NFP  = 2,
  // With no forward ports the forward inputs keep a 1-bit stub and are ignored
  localparam int FW  = (NFP > 0) ? NFP : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_latch,
  input  logic [NRP-1:0]       i_re,
  input  logic [5*NRP-1:0]     i_raddr,
  output logic [XLEN*NRP-1:0]  o_rdata,
  output logic [NRP-1:0]       o_busy,
  input  logic [FW-1:0]        i_fwd,
  input  logic [5*FW-1:0]      i_faddr,
  input  logic [XLEN*FW-1:0]   i_fdata,
  input  logic                 i_we,
  input  logic [4:0]           i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic                 i_set_busy,
  input  logic [4:0]           i_set_addr
);

  localparam int         AW       = $clog2(NREG);
  localparam logic [5:0] NREG_LIM = 6'(NREG);

  logic [XLEN-1:0]          mem_q [NREG];
  logic [XLEN-1:0]          mem_d [NREG];
  logic [NREG-1:0]          sb_q, sb_d;
  logic [NRP-1:0][XLEN-1:0] rdata_q, rdata_d;
  logic [NRP-1:0]           busy_q, busy_d;

  logic w_wr_ok;
  logic w_set_ok;

  // Writes and scoreboard updates only target real, nonzero registers
  assign w_wr_ok  = i_we && (i_waddr != 5'd0) && ({1'b0, i_waddr} < NREG_LIM);
  assign w_set_ok = i_set_busy && (i_set_addr != 5'd0) && ({1'b0, i_set_addr} < NREG_LIM);

  // Next storage and scoreboard; a set after the clear lets the new producer win
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      mem_d[r] = mem_q[r];
    end
    sb_d = sb_q;
    if (w_wr_ok) begin
      mem_d[i_waddr[AW-1:0]] = i_wdata;
      sb_d[i_waddr[AW-1:0]]  = 1'b0;
    end
    if (w_set_ok) begin
      sb_d[i_set_addr[AW-1:0]] = 1'b1;
    end
  end

  // Per-port read result: latch hold, invalid->zero, forward, write bypass, storage
  always_comb begin
    logic [4:0] ra;
    logic       hit;
    ra      = 5'd0;
    hit     = 1'b0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    for (int p = 0; p < NRP; p++) begin
      ra  = i_raddr[5*p +: 5];
      hit = 1'b0;
      if (!rd_latch) begin
        if (!i_re[p] || (ra == 5'd0) || ({1'b0, ra} >= NREG_LIM)) begin
          rdata_d[p] = '0;
          busy_d[p]  = 1'b0;
        end else begin
          for (int f = 0; f < NFP; f++) begin
            if (!hit && i_fwd[f] && (i_faddr[5*f +: 5] == ra)) begin
              rdata_d[p] = i_fdata[XLEN*f +: XLEN];
              busy_d[p]  = 1'b0;
              hit        = 1'b1;
            end
          end
          if (!hit) begin
            if (i_we && (i_waddr == ra)) begin
              rdata_d[p] = i_wdata;
              busy_d[p]  = 1'b0;
            end else begin
              rdata_d[p] = mem_q[ra[AW-1:0]];
              busy_d[p]  = sb_q[ra[AW-1:0]];
            end
          end
        end
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
      sb_q    <= '0;
      rdata_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= mem_d[r];
      end
      sb_q    <= sb_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rdata = rdata_q;
  assign o_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_core_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_regfile_mp
//  Purpose  : Directed self-checking bench for core_regfile_mp (NREG=32 and
//             an NREG=16 instance sharing the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_latch;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [1:0]  fwd;
  logic [9:0]  faddr;
  logic [63:0] fdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        set_busy;
  logic [4:0]  set_addr;
  logic [63:0] rdata, rdata16;
  logic [1:0]  busy, busy16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  core_regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_latch(rd_latch),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata), .o_busy(busy),
    .i_fwd(fwd), .i_faddr(faddr), .i_fdata(fdata),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr)
  );

  core_regfile_mp #(.NREG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rd_latch(rd_latch),
    .i_re(re), .i_raddr(raddr), .o_rdata(rdata16), .o_busy(busy16),
    .i_fwd(fwd), .i_faddr(faddr), .i_fdata(fdata),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    rd_latch = 1'b0; re = '0; raddr = '0; fwd = '0; faddr = '0; fdata = '0;
    we = 1'b0; waddr = '0; wdata = '0; set_busy = 1'b0; set_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("reset_rdata", rdata, 64'h0);
    check("reset_busy", {62'd0, busy}, 64'h0);
    #9 rst_n = 1'b1;

    // Write x5 then read it on both ports
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle(); re = 2'b11; raddr = {5'd5, 5'd5};
    tick();
    check("x5_p0", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
    check("x5_p1", {32'd0, rdata[63:32]}, 64'hDEADBEEF);
    check("x5_busy", {62'd0, busy}, 64'h0);

    // Forward/write priority on x7
    idle(); re = 2'b01; raddr = {5'd0, 5'd7};
    fwd = 2'b11; faddr = {5'd7, 5'd7}; fdata = {32'h22, 32'h11};
    we = 1'b1; waddr = 5'd7; wdata = 32'h33;
    tick();
    check("fwd0_wins", {32'd0, rdata[31:0]}, 64'h11);
    fwd = 2'b10;
    tick();
    check("fwd1_wins", {32'd0, rdata[31:0]}, 64'h22);
    fwd = 2'b00;
    tick();
    check("wr_bypass", {32'd0, rdata[31:0]}, 64'h33);

    // x0 forwarded with nonzero data still reads zero
    idle(); re = 2'b01; raddr = 10'd0; fwd = 2'b01; faddr = 10'd0; fdata = 64'hAB;
    tick();
    check("x0_fwd", {32'd0, rdata[31:0]}, 64'h0);
    check("x0_fwd_16", {32'd0, rdata16[31:0]}, 64'h0);

    // x20 exists only in the 32-entry instance
    idle(); we = 1'b1; waddr = 5'd20; wdata = 32'hFF;
    tick();
    idle(); re = 2'b01; raddr = {5'd0, 5'd20};
    tick();
    check("x20_n16", {32'd0, rdata16[31:0]}, 64'h0);
    check("x20_n16_busy", {62'd0, busy16}, 64'h0);
    check("x20_n32", {32'd0, rdata[31:0]}, 64'hFF);

    // Scoreboard on x9
    idle(); set_busy = 1'b1; set_addr = 5'd9;
    tick();
    idle(); re = 2'b01; raddr = {5'd0, 5'd9};
    tick();
    check("x9_busy", {62'd0, busy}, 64'h1);
    check("x9_data0", {32'd0, rdata[31:0]}, 64'h0);
    we = 1'b1; waddr = 5'd9; wdata = 32'h5;
    tick();
    check("x9_wr_data", {32'd0, rdata[31:0]}, 64'h5);
    check("x9_wr_busy", {62'd0, busy}, 64'h0);
    we = 1'b0;
    tick();
    check("x9_cleared", {62'd0, busy}, 64'h0);
    idle(); set_busy = 1'b1; set_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h6;
    tick();
    idle(); re = 2'b01; raddr = {5'd0, 5'd9};
    tick();
    check("set_wins_busy", {62'd0, busy}, 64'h1);
    check("set_wins_data", {32'd0, rdata[31:0]}, 64'h6);

    // rd_latch hold
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    tick();
    idle(); re = 2'b01; raddr = {5'd0, 5'd3};
    tick();
    check("x3_77", {32'd0, rdata[31:0]}, 64'h77);
    rd_latch = 1'b1; raddr = {5'd0, 5'd9}; we = 1'b1; waddr = 5'd3; wdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("latch_data", {32'd0, rdata[31:0]}, 64'h77);
      check("latch_busy", {62'd0, busy}, 64'h0);
    end
    idle(); re = 2'b01; raddr = {5'd0, 5'd3};
    tick();
    check("unlatch_x3", {32'd0, rdata[31:0]}, 64'h99);
    re = 2'b00;
    tick();
    check("re_off", {32'd0, rdata[31:0]}, 64'h0);

    // Asynchronous reset mid-cycle
    idle(); we = 1'b1; waddr = 5'd10; wdata = 32'hA5;
    tick();
    idle(); re = 2'b11; raddr = {5'd9, 5'd3};
    tick();
    check("pre_rst_x3", {32'd0, rdata[31:0]}, 64'h99);
    check("pre_rst_x9_busy", {62'd0, busy}, 64'h2);
    check("pre_rst_x9", {32'd0, rdata[63:32]}, 64'h6);
    we = 1'b1; waddr = 5'd10; wdata = 32'h55;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_data", rdata, 64'h0);
    check("rst_async_busy", {62'd0, busy}, 64'h0);
    idle(); re = 2'b11; raddr = {5'd10, 5'd3};
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_x3", {32'd0, rdata[31:0]}, 64'h0);
    check("post_rst_x10", {32'd0, rdata[63:32]}, 64'h0);
    raddr = {5'd20, 5'd9};
    tick();
    check("post_rst_x9_busy", {62'd0, busy}, 64'h0);
    check("post_rst_x20", {32'd0, rdata[63:32]}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_regfile_mp.md
CORE_REGFILE_MP -- requirements
Module: core_regfile_mp

Interface
- REQ-001: Parameter XLEN, default 32, data width of every register, forward and write port.
- REQ-002: Parameter NREG, default 32, number of architectural registers; legal values are 16 (RV32E) and 32.
- REQ-003: Parameter NRP, default 2, number of read ports (1..4).
- REQ-004: Parameter NFP, default 2, number of forward ports (0..4).
- REQ-005: clk  input  1  clock; all state updates on its rising edge.
- REQ-006: rst_n  input  1  reset, asynchronous, active-low.
- REQ-007: rd_latch  input  1  hold all read outputs for the cycle.
- REQ-008: i_re  input  NRP  per-port read enable.
- REQ-009: i_raddr  input  5*NRP  per-port read address; port p occupies bits [5p+4:5p].
- REQ-010: o_rdata  output  XLEN*NRP  per-port registered read data.
- REQ-011: o_busy  output  NRP  per-port registered scoreboard-pending flag.
- REQ-012: i_fwd / i_faddr / i_fdata  input  NFP / 5*NFP / XLEN*NFP  forward valid, address and data.
- REQ-013: i_we / i_waddr / i_wdata  input  1 / 5 / XLEN  write port.
- REQ-014: i_set_busy / i_set_addr  input  1 / 5  mark a destination register pending.

Function
- REQ-015: Storage SHALL be flop-based, NREG x XLEN; register 0 SHALL always read as zero and SHALL ignore writes.
- REQ-016: A write with i_we=1 SHALL update storage at the edge only when i_waddr is nonzero and below NREG.
- REQ-017: Each read port SHALL have a 1-cycle latency: o_rdata[p] and o_busy[p] reflect the address sampled at the previous edge.
- REQ-018: Each port SHALL update at each edge using this priority, highest first.
- REQ-018a: rd_latch=1 -> o_rdata and o_busy keep their current values.
- REQ-018b: i_re[p]=0, or address 0, or address >= NREG -> data 0, busy 0.
- REQ-018c: Forward port f with i_fwd[f]=1 and i_faddr[f]=raddr -> i_fdata[f], busy 0; the lowest matching f wins.
- REQ-018d: i_we=1 and i_waddr=raddr -> i_wdata, busy 0.
- REQ-018e: Otherwise -> storage[raddr], busy = scoreboard[raddr].
- REQ-019: The scoreboard SHALL hold 1 bit per register. i_set_busy sets the bit of i_set_addr; a valid write (REQ-016) clears the bit of i_waddr.
- REQ-020: When set and clear target the same address in the same cycle, set SHALL win, because the new producer supersedes the old one.
- REQ-021: The scoreboard bit for register 0, or for any address >= NREG, SHALL never be set.
- REQ-022: Multiple read ports addressing the same register SHALL return identical data and busy values in the same cycle.
- REQ-023: A forward or write address of 0 SHALL never override the zero result of REQ-018b.
- REQ-024: With NFP=0, all forward inputs SHALL be absent and priority SHALL continue directly from REQ-018b to REQ-018d.

Reset
- REQ-025: While rst_n=0, all storage, the scoreboard, o_rdata and o_busy SHALL be 0, asynchronously.
- REQ-026: Reset asserted mid-operation SHALL discard any pending write and scoreboard updates; the first edge after release SHALL behave as a normal cycle.

Verification
- V-1: Write x5=0xDEADBEEF; next cycle read x5 on port 0 -> o_rdata[0]=0xDEADBEEF one cycle later; o_busy[0]=0.
- V-2: Same cycle: fwd0 x7=0x11, fwd1 x7=0x22, write x7=0x33, read x7 -> 0x11. Drop fwd0 -> 0x22. Drop fwd1 -> 0x33.
- V-3: NREG=16: write x20=0xFF, then read x20 -> 0, o_busy=0; x0 forwarded with 0xAB -> reads 0.
- V-4: i_set_busy x9, next cycle read x9 -> o_busy=1. Write x9=0x5 with simultaneous read -> data 0x5, busy 0. Set and write x9 in the same cycle -> the following read shows busy 1.
- V-5: Read x3=0x77, then hold rd_latch=1 for 3 cycles while writing x3=0x99 and changing the address -> output stays 0x77. Release rd_latch -> new read result.
- V-6: Assert rst_n=0 asynchronously between edges after writes -> o_rdata, o_busy and all registers read 0 immediately and after release.
